bus: RTL and testbench

BUS -- requirements
Module: bus

---
 rtl/bus.sv | 134 +++++++++++++
 tb/tb_bus.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bus.sv
// rtl/bus.sv - 24-source priority-encoded datapath bus with sticky conflict flag
module bus (
   input  logic        clock,
   input  logic        reset,
   input  logic        R0out,
   input  logic        R1out,
   input  logic        R2out,
   input  logic        R3out,
   input  logic        R4out,
   input  logic        R5out,
   input  logic        R6out,
   input  logic        R7out,
   input  logic        R8out,
   input  logic        R9out,
   input  logic        R10out,
   input  logic        R11out,
   input  logic        R12out,
   input  logic        R13out,
   input  logic        R14out,
   input  logic        R15out,
   input  logic        HIout,
   input  logic        LOout,
   input  logic        Zhighout,
   input  logic        Zlowout,
   input  logic        PCout,
   input  logic        MDRout,
   input  logic        InPortout,
   input  logic        Cout,
   input  logic [31:0] BusMuxInR0,
   input  logic [31:0] BusMuxInR1,
   input  logic [31:0] BusMuxInR2,
   input  logic [31:0] BusMuxInR3,
   input  logic [31:0] BusMuxInR4,
   input  logic [31:0] BusMuxInR5,
   input  logic [31:0] BusMuxInR6,
   input  logic [31:0] BusMuxInR7,
   input  logic [31:0] BusMuxInR8,
   input  logic [31:0] BusMuxInR9,
   input  logic [31:0] BusMuxInR10,
   input  logic [31:0] BusMuxInR11,
   input  logic [31:0] BusMuxInR12,
   input  logic [31:0] BusMuxInR13,
   input  logic [31:0] BusMuxInR14,
   input  logic [31:0] BusMuxInR15,
   input  logic [31:0] BusMuxInHi,
   input  logic [31:0] BusMuxInLo,
   input  logic [31:0] BusMuxInZhi,
   input  logic [31:0] BusMuxInZlo,
   input  logic [31:0] BusMuxInPC,
   input  logic [31:0] BusMuxInMDR,
   input  logic [31:0] BusMuxInPort,
   input  logic [31:0] BusMuxInCin,
   output logic [31:0] BusMuxOut,
   output logic [4:0]  BusSel,
   output logic        BusConflict
);

   localparam int NumSrc = 24;

   logic [NumSrc-1:0] selVec;
   logic [31:0]       srcData [NumSrc];
   logic [31:0]       muxData;
   logic              anySel;
   logic              multiSel;

   // Bit position in selVec is the source index seen on BusSel.
   assign selVec = {Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                    R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

   assign srcData[0]  = BusMuxInR0;
   assign srcData[1]  = BusMuxInR1;
   assign srcData[2]  = BusMuxInR2;
   assign srcData[3]  = BusMuxInR3;
   assign srcData[4]  = BusMuxInR4;
   assign srcData[5]  = BusMuxInR5;
   assign srcData[6]  = BusMuxInR6;
   assign srcData[7]  = BusMuxInR7;
   assign srcData[8]  = BusMuxInR8;
   assign srcData[9]  = BusMuxInR9;
   assign srcData[10] = BusMuxInR10;
   assign srcData[11] = BusMuxInR11;
   assign srcData[12] = BusMuxInR12;
   assign srcData[13] = BusMuxInR13;
   assign srcData[14] = BusMuxInR14;
   assign srcData[15] = BusMuxInR15;
   assign srcData[16] = BusMuxInHi;
   assign srcData[17] = BusMuxInLo;
   assign srcData[18] = BusMuxInZhi;
   assign srcData[19] = BusMuxInZlo;
   assign srcData[20] = BusMuxInPC;
   assign srcData[21] = BusMuxInMDR;
   assign srcData[22] = BusMuxInPort;
   assign srcData[23] = BusMuxInCin;

   assign anySel = |selVec;
   // Clearing the lowest set bit leaves something only when two or more selects are high.
   assign multiSel = (selVec & (selVec - 24'd1)) != '0;

   // Priority encoder: scan from the top so the lowest active index is written last and wins.
   always_comb begin
      BusSel = '0;
      for (int i = NumSrc - 1; i >= 0; i--) begin
         if (selVec[i]) begin
            BusSel = i[4:0];
         end
      end
   end

   // 24:1 mux keyed on the encoded index; codes 24..31 never occur and fall to zero.
   always_comb begin
      muxData = '0;
      for (int i = 0; i < NumSrc; i++) begin
         if (BusSel == i[4:0]) begin
            muxData = srcData[i];
         end
      end
   end

   // An idle bus reads as zero rather than R0, whose code it shares.
   always_comb begin
      BusMuxOut = anySel ? muxData : 32'h0000_0000;
   end

   // Sticky conflict flag; reset wins over a conflict seen on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         BusConflict <= 1'b0;
      end else if (multiSel) begin
         BusConflict <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bus.sv
// tb/tb_bus.sv - directed self-checking bench for bus
module tb_bus;

   logic        clock;
   logic        reset;
   logic [23:0] sel;
   logic [31:0] src [24];
   logic [31:0] BusMuxOut;
   logic [4:0]  BusSel;
   logic        BusConflict;

   int errCount;
   int checkCount;

   bus dut (
      .clock(clock), .reset(reset),
      .R0out(sel[0]), .R1out(sel[1]), .R2out(sel[2]), .R3out(sel[3]),
      .R4out(sel[4]), .R5out(sel[5]), .R6out(sel[6]), .R7out(sel[7]),
      .R8out(sel[8]), .R9out(sel[9]), .R10out(sel[10]), .R11out(sel[11]),
      .R12out(sel[12]), .R13out(sel[13]), .R14out(sel[14]), .R15out(sel[15]),
      .HIout(sel[16]), .LOout(sel[17]), .Zhighout(sel[18]), .Zlowout(sel[19]),
      .PCout(sel[20]), .MDRout(sel[21]), .InPortout(sel[22]), .Cout(sel[23]),
      .BusMuxInR0(src[0]), .BusMuxInR1(src[1]), .BusMuxInR2(src[2]), .BusMuxInR3(src[3]),
      .BusMuxInR4(src[4]), .BusMuxInR5(src[5]), .BusMuxInR6(src[6]), .BusMuxInR7(src[7]),
      .BusMuxInR8(src[8]), .BusMuxInR9(src[9]), .BusMuxInR10(src[10]), .BusMuxInR11(src[11]),
      .BusMuxInR12(src[12]), .BusMuxInR13(src[13]), .BusMuxInR14(src[14]), .BusMuxInR15(src[15]),
      .BusMuxInHi(src[16]), .BusMuxInLo(src[17]), .BusMuxInZhi(src[18]), .BusMuxInZlo(src[19]),
      .BusMuxInPC(src[20]), .BusMuxInMDR(src[21]), .BusMuxInPort(src[22]), .BusMuxInCin(src[23]),
      .BusMuxOut(BusMuxOut), .BusSel(BusSel), .BusConflict(BusConflict)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full clock cycle; outputs are sampled well after the rising edge.
   task automatic pulseClock();
      #5 clock = 1'b1;
      #5 clock = 1'b0;
   endtask

   task automatic checkBus(input string tag, input logic [31:0] expOut, input logic [4:0] expSel);
      checkVal({tag, ".out"}, BusMuxOut, expOut);
      checkVal({tag, ".sel"}, {27'd0, BusSel}, {27'd0, expSel});
   endtask

   task automatic selectOne(input int idx);
      sel = '0;
      sel[idx] = 1'b1;
   endtask

   int          stepIdx [6] = '{1, 5, 19, 20, 21, 23};
   logic [31:0] stepOut [6] = '{32'hBBBB1111, 32'hFFFF5555, 32'hEEEE4444,
                               32'hFFFF5555, 32'h11116666, 32'h33338888};

   initial begin
      errCount   = 0;
      checkCount = 0;
      clock      = 1'b0;
      reset      = 1'b1;
      sel        = '0;
      for (int i = 0; i < 24; i++) src[i] = 32'h0101_0000 * i + 32'h0000_00A0 + i;
      src[0]  = 32'hAAAA0000;
      src[1]  = 32'hBBBB1111;
      src[2]  = 32'hBBBB2222;
      src[5]  = 32'hFFFF5555;
      src[16] = 32'h12345678;
      src[19] = 32'hEEEE4444;
      src[20] = 32'hFFFF5555;
      src[21] = 32'h11116666;
      src[23] = 32'h33338888;

      pulseClock();
      checkVal("reset.conflict", {31'd0, BusConflict}, 32'd0);
      reset = 1'b0;
      #1;
      checkBus("idle", 32'h0, 5'd0);
      checkVal("idle.known", {31'd0, $isunknown(BusMuxOut)}, 32'd0);

      selectOne(0);
      #5;
      checkBus("r0", 32'hAAAA0000, 5'd0);

      for (int k = 0; k < 6; k++) begin
         selectOne(stepIdx[k]);
         #5;
         checkBus($sformatf("step%0d", k), stepOut[k], stepIdx[k][4:0]);
      end

      selectOne(16);
      #1;
      checkBus("hi", 32'h12345678, 5'd16);

      // Lowest index wins among several selects.
      sel = '0; sel[15] = 1'b1; sel[16] = 1'b1; sel[23] = 1'b1;
      #1;
      checkBus("prio15", src[15], 5'd15);

      sel = '0;
      #5;
      checkBus("none", 32'h0, 5'd0);

      // Single and empty selects across edges must not set the flag.
      selectOne(21);
      pulseClock();
      sel = '0;
      pulseClock();
      checkVal("single.noconflict", {31'd0, BusConflict}, 32'd0);

      sel = '0; sel[5] = 1'b1; sel[20] = 1'b1;
      #1;
      checkBus("r5pc", 32'hFFFF5555, 5'd5);
      checkVal("r5pc.before", {31'd0, BusConflict}, 32'd0);
      pulseClock();
      checkVal("r5pc.conflict", {31'd0, BusConflict}, 32'd1);

      selectOne(21);
      pulseClock();
      checkVal("sticky", {31'd0, BusConflict}, 32'd1);
      sel = '0;
      pulseClock();
      checkVal("sticky.idle", {31'd0, BusConflict}, 32'd1);

      reset = 1'b1;
      pulseClock();
      reset = 1'b0;
      checkVal("cleared", {31'd0, BusConflict}, 32'd0);

      // Re-arm the flag, then reset together with a new conflict.
      sel = '0; sel[0] = 1'b1; sel[23] = 1'b1;
      pulseClock();
      checkVal("rearm", {31'd0, BusConflict}, 32'd1);

      sel = '0; sel[1] = 1'b1; sel[2] = 1'b1;
      reset = 1'b1;
      #1;
      checkBus("rstprio.pre", 32'hBBBB1111, 5'd1);
      pulseClock();
      checkVal("rstprio.conflict", {31'd0, BusConflict}, 32'd0);
      checkBus("rstprio.post", 32'hBBBB1111, 5'd1);
      pulseClock();
      checkVal("rstprio.hold", {31'd0, BusConflict}, 32'd0);
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
